ascon_hash_deser: RTL

//  Downstream collector for the serial Ascon hash core. Samples the core's
//  bit-serial digest (hash_textxSO, LSB first, one bit per clock once readyxSO

---
 rtl/ascon_hash_deser.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ascon_hash_deser.sv
// ascon_hash_deser: collects the bit-serial Ascon digest (LSB first) after the
// core's ready level rises, rebuilds the L-bit digest in parallel and presents
// it with a valid/ack handshake. A ready drop mid-capture aborts the capture
// and sets a sticky error flag.
//
// Parameters: L (digest bits, >= 2), SKIP (cycles from the first ready=1
//   sample to bit 0; the arm cycle itself counts as the first skip cycle),
//   CW (counter width, 2**CW > L and 2**CW > SKIP).
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   hash_bitxSI       serial digest bit from the core
//   hash_readyxSI     core ready level
//   digest_ackxSI     consumer accepts the held digest
//   digestxDO         assembled digest, bit k = k-th serial bit
//   digest_validxSO   digest held stable until acked
//   busyxSO           capture in progress (ALIGN or SHIFT)
//   errorxSO          sticky: last capture aborted
// Optional feature (macro ASCON_DESER_CMP_EN): adds exp_digestxDI and
//   matchxSO, a known-answer compare registered together with the valid rise.
module ascon_hash_deser #(
  parameter int unsigned L    = 256,
  parameter int unsigned SKIP = 1,
  parameter int unsigned CW   = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hash_bitxSI,
  input  logic         hash_readyxSI,
  input  logic         digest_ackxSI,
`ifdef ASCON_DESER_CMP_EN
  input  logic [L-1:0] exp_digestxDI,
  output logic         matchxSO,
`endif
  output logic [L-1:0] digestxDO,
  output logic         digest_validxSO,
  output logic         busyxSO,
  output logic         errorxSO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SHIFT,
    S_HOLD,
    S_WAITLOW
  } state_e;

  localparam logic [CW-1:0] LastBit   = CW'(L - 1);
  // ALIGN covers the skip cycles remaining after the arm cycle
  localparam logic [CW-1:0] AlignLast = CW'(SKIP - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  shift_q, shift_d;
  logic [L-1:0]  digest_q, digest_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          ready_q;
  logic          arm;
  logic [L-1:0]  shifted;
`ifdef ASCON_DESER_CMP_EN
  logic          match_q, match_d;
`endif

  assign arm     = hash_readyxSI & ~ready_q;
  assign shifted = {hash_bitxSI, shift_q[L-1:1]};

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    digest_d = digest_q;
    valid_d  = valid_q;
    error_d  = error_q;
`ifdef ASCON_DESER_CMP_EN
    match_d  = match_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          error_d = 1'b0;
          cnt_d   = '0;
          if (SKIP == 0) begin
            // bit 0 arrives together with the ready rise
            shift_d = shifted;
            cnt_d   = CW'(1);
            state_d = S_SHIFT;
          end else if (SKIP == 1) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        if (!hash_readyxSI) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == AlignLast) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (!hash_readyxSI) begin
          // truncated digest: keep the previous result, drop partial bits
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          shift_d = shifted;
          if (cnt_q == LastBit) begin
            digest_d = shifted;
            valid_d  = 1'b1;
`ifdef ASCON_DESER_CMP_EN
            match_d  = (shifted == exp_digestxDI);
`endif
            state_d  = S_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_HOLD: begin
        if (digest_ackxSI) begin
          valid_d = 1'b0;
`ifdef ASCON_DESER_CMP_EN
          match_d = 1'b0;
`endif
          state_d = hash_readyxSI ? S_WAITLOW : S_IDLE;
        end
      end
      S_WAITLOW: begin
        // ready is a level; wait for it to drop before re-arming
        if (!hash_readyxSI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ALIGN) || (state_d == S_SHIFT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      digest_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      ready_q  <= 1'b0;
`ifdef ASCON_DESER_CMP_EN
      match_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      digest_q <= digest_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
      ready_q  <= hash_readyxSI;
`ifdef ASCON_DESER_CMP_EN
      match_q  <= match_d;
`endif
    end
  end

  assign digestxDO       = digest_q;
  assign digest_validxSO = valid_q;
  assign busyxSO         = busy_q;
  assign errorxSO        = error_q;
`ifdef ASCON_DESER_CMP_EN
  assign matchxSO        = match_q;
`endif

endmodule
